hdmi_pll_lock_ctrl: RTL and testbench

Reset/lock sequencer for the HDMI TX pixel PLL (50 MHz ref in, 297 MHz out).
- Drives the PLL's active-high reset and watches its lock output.
- Qualifies lock with a stability window, retries on lock timeout, and detects loss of lock.
- Releases the downstream HDMI TX reset only while the PLL is locked and stable.
- Runs in the 50 MHz reference clock domain, next to the PLL wrapper in the HDMI TX clocking subsystem.

---
 rtl/hdmi_pll_lock_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_hdmi_pll_lock_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_pll_lock_ctrl.sv
`timescale 1ns/1ps
// hdmi_pll_lock_ctrl
// Reset/lock sequencer for the HDMI TX pixel PLL, clocked by the 50 MHz
// reference. Holds the PLL in reset for a fixed time, waits for lock with a
// timeout and bounded retries, qualifies lock over a stability window and
// only then releases the downstream HDMI TX reset. Loss of lock in RUN
// restarts the sequence and is counted.
//
// Ports:
//   refclk      : 50 MHz reference clock, rising edge
//   rst_n       : asynchronous active-low reset
//   enable      : 1 = bring up PLL, 0 = hold PLL in reset (IDLE)
//   relock_req  : single-cycle pulse, restarts the reset/lock sequence
//   pll_locked  : PLL lock output (asynchronous, synchronized internally)
//   pll_rst     : active-high PLL reset
//   tx_rst_n    : active-low reset to the HDMI TX logic (released in RUN)
//   ready       : PLL locked and qualified
//   fault       : retries exhausted
//   retry_count : failed lock attempts in the current bring-up (sat. 15)
//   lol_count   : loss-of-lock events seen in RUN (sat. 255)
module hdmi_pll_lock_ctrl #(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       relock_req,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       tx_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lol_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  // retry_count saturates at 15, so a larger limit is clamped to keep the
  // FAULT exit reachable.
  localparam int unsigned      RETRY_CAP    = (MAX_RETRIES > 15) ? 15 : MAX_RETRIES;
  localparam logic [3:0]       RETRY_LIMIT  = 4'(RETRY_CAP);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       lol_q, lol_d;
  logic             pll_rst_q, pll_rst_d;
  logic             run_q, run_d;
  logic             fault_q, fault_d;
  logic             sync1_q, locked_s_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lol_d   = lol_q;

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (relock_req) begin
      state_d = ST_RESET;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_RESET;
          cnt_d   = '0;
          retry_d = '0;
        end
        ST_RESET: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          // Lock is checked first so a lock arriving on the timeout cycle wins.
          if (locked_s_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q < RETRY_LIMIT) begin
              retry_d = retry_q + 4'd1;
              state_d = ST_RESET;
            end else begin
              state_d = ST_FAULT;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          // A dropout here is a glitch: back to WAIT_LOCK, no retry consumed.
          if (!locked_s_q) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!locked_s_q) begin
            state_d = ST_RESET;
            cnt_d   = '0;
            lol_d   = (lol_q == 8'hFF) ? lol_q : lol_q + 8'd1;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_comb begin
    pll_rst_d = (state_d == ST_IDLE) || (state_d == ST_RESET) || (state_d == ST_FAULT);
    run_d     = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      retry_q    <= '0;
      lol_q      <= '0;
      pll_rst_q  <= 1'b1;
      run_q      <= 1'b0;
      fault_q    <= 1'b0;
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      lol_q      <= lol_d;
      pll_rst_q  <= pll_rst_d;
      run_q      <= run_d;
      fault_q    <= fault_d;
      sync1_q    <= pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign tx_rst_n    = run_q;
  assign ready       = run_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
  assign lol_count   = lol_q;

endmodule

// File: tb/tb_hdmi_pll_lock_ctrl.sv
`timescale 1ns/1ps
// tb_hdmi_pll_lock_ctrl
// Scenario tasks for the PLL lock sequencer with small parameters, plus a
// randomized run compared cycle by cycle against a phase/age reference model.
module tb_hdmi_pll_lock_ctrl;

  localparam int HOLD = 4;
  localparam int TMO  = 100;
  localparam int STB  = 16;
  localparam int MAXR = 2;
  localparam int SYNC = 2;

  localparam int P_IDLE = 0, P_RESET = 1, P_WAIT = 2, P_STABLE = 3, P_RUN = 4, P_FAULT = 5;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, tx_rst_n, ready, fault;
  logic [3:0] retry_count;
  logic [7:0] lol_count;
  logic [15:0] dut_vec;

  int errors = 0;
  int checks = 0;

  localparam logic [15:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};

  hdmi_pll_lock_ctrl #(
    .RST_HOLD_CYCLES    (HOLD),
    .LOCK_TIMEOUT_CYCLES(TMO),
    .LOCK_STABLE_CYCLES (STB),
    .MAX_RETRIES        (MAXR),
    .CNT_W              (8)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .enable     (enable),
    .relock_req (relock_req),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .tx_rst_n   (tx_rst_n),
    .ready      (ready),
    .fault      (fault),
    .retry_count(retry_count),
    .lol_count  (lol_count)
  );

  always #10 refclk = ~refclk;

  assign dut_vec = {pll_rst, tx_rst_n, ready, fault, retry_count, lol_count};

  // Reference model: phase plus cycles spent in it, lock seen through a
  // two-sample history.
  int m_phase = P_IDLE;
  int m_age = 0;
  int m_retries = 0;
  int m_lol = 0;
  bit m_s1 = 1'b0;
  bit m_ls = 1'b0;

  always @(posedge refclk or negedge rst_n) begin : model
    bit ls;
    if (!rst_n) begin
      m_phase = P_IDLE; m_age = 0; m_retries = 0; m_lol = 0;
      m_s1 = 1'b0; m_ls = 1'b0;
    end else begin
      ls   = m_ls;
      m_ls = m_s1;
      m_s1 = pll_locked;
      if (!enable) begin
        m_phase = P_IDLE; m_age = 0;
      end else if (relock_req) begin
        m_phase = P_RESET; m_age = 0; m_retries = 0;
      end else begin
        m_age++;
        case (m_phase)
          P_IDLE: begin m_phase = P_RESET; m_age = 0; m_retries = 0; end
          P_RESET: if (m_age == HOLD) begin m_phase = P_WAIT; m_age = 0; end
          P_WAIT: begin
            if (ls) begin
              m_phase = P_STABLE; m_age = 0;
            end else if (m_age == TMO) begin
              m_age = 0;
              if (m_retries < MAXR) begin m_retries++; m_phase = P_RESET; end
              else m_phase = P_FAULT;
            end
          end
          P_STABLE: begin
            if (!ls) begin m_phase = P_WAIT; m_age = 0; end
            else if (m_age == STB) begin m_phase = P_RUN; m_age = 0; end
          end
          P_RUN: if (!ls) begin
            m_phase = P_RESET; m_age = 0;
            m_lol = (m_lol < 255) ? m_lol + 1 : 255;
          end
          default: m_age = 0;
        endcase
      end
    end
  end

  function automatic logic [15:0] model_outs();
    logic prst;
    prst = (m_phase == P_IDLE) || (m_phase == P_RESET) || (m_phase == P_FAULT);
    return {prst, m_phase == P_RUN, m_phase == P_RUN, m_phase == P_FAULT,
            4'(m_retries), 8'(m_lol)};
  endfunction

  task automatic test_reset();
    #5 rst_n = 1'b0;
    #40;
    checks++;
    if (dut_vec !== RESET_VEC) begin
      errors++; $display("FAIL reset_values: got %h expected %h", dut_vec, RESET_VEC);
    end
    @(negedge refclk); rst_n = 1'b1;
    repeat (3) @(posedge refclk);
    #1;
    checks++;
    if (pll_rst !== 1'b1 || ready !== 1'b0) begin
      errors++; $display("FAIL idle_disabled: got pll_rst=%b ready=%b expected 1 0", pll_rst, ready);
    end
  endtask

  task automatic test_clean_bringup();
    int n;
    @(negedge refclk); enable = 1'b1;
    // Edge 1 leaves IDLE, then HOLD edges in RESET.
    n = 0;
    do begin @(posedge refclk); #1; n++; end while (pll_rst && n < 50);
    checks++;
    if (n != HOLD + 1) begin
      errors++; $display("FAIL bringup_rst_len: got %0d expected %0d", n, HOLD + 1);
    end
    repeat (9) @(posedge refclk);
    @(negedge refclk); pll_locked = 1'b1;
    // First edge sampling the lock counts as 1.
    n = 0;
    do begin @(posedge refclk); #1; n++; end while (!ready && n < 200);
    checks++;
    if (n != SYNC + STB + 1) begin
      errors++; $display("FAIL bringup_ready_latency: got %0d expected %0d", n, SYNC + STB + 1);
    end
    checks++;
    if ({tx_rst_n, pll_rst, fault, retry_count} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      errors++; $display("FAIL bringup_outputs: got %b expected 1000000",
                         {tx_rst_n, pll_rst, fault, retry_count});
    end
  endtask

  task automatic test_loss_of_lock();
    int drop_at, hi, fell_at, n;
    drop_at = 0; hi = 0; fell_at = 0;
    @(negedge refclk); pll_locked = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge refclk); #1;
      if ((!ready || !tx_rst_n) && drop_at == 0) drop_at = k;
      if (pll_rst) hi++;
      else if (hi > 0) begin fell_at = k; break; end
      @(negedge refclk);
      if (k == 5) pll_locked = 1'b1;
    end
    checks++;
    if (drop_at != SYNC + 1) begin
      errors++; $display("FAIL lol_ready_drop: got %0d expected %0d", drop_at, SYNC + 1);
    end
    checks++;
    if (hi != HOLD || fell_at != SYNC + 1 + HOLD) begin
      errors++; $display("FAIL lol_rst_pulse: got len=%0d fall=%0d expected len=%0d fall=%0d",
                         hi, fell_at, HOLD, SYNC + 1 + HOLD);
    end
    checks++;
    if (lol_count !== 8'd1) begin
      errors++; $display("FAIL lol_count: got %0d expected 1", lol_count);
    end
    n = 0;
    do begin @(posedge refclk); #1; n++; end while (!ready && n < 200);
    checks++;
    if ({ready, retry_count} !== {1'b1, 4'd0}) begin
      errors++; $display("FAIL lol_relock: got ready=%b retry=%0d expected 1 0", ready, retry_count);
    end
  endtask

  task automatic test_lock_glitch();
    int n, rst_seen, rdy_seen;
    @(negedge refclk); pll_locked = 1'b0; relock_req = 1'b1;
    @(negedge refclk); relock_req = 1'b0;
    n = 0;
    do begin @(posedge refclk); #1; n++; end while (pll_rst && n < 50);
    checks++;
    if (n != HOLD || lol_count !== 8'd1) begin
      errors++; $display("FAIL glitch_relock: got n=%0d lol=%0d expected %0d 1", n, lol_count, HOLD);
    end
    rst_seen = 0; rdy_seen = 0;
    @(negedge refclk); pll_locked = 1'b1;
    repeat (8) begin @(posedge refclk); #1; rst_seen += int'(pll_rst); rdy_seen += int'(ready); end
    @(negedge refclk); pll_locked = 1'b0;
    repeat (3) begin @(posedge refclk); #1; rst_seen += int'(pll_rst); rdy_seen += int'(ready); end
    @(negedge refclk); pll_locked = 1'b1;
    n = 0;
    do begin @(posedge refclk); #1; n++; rst_seen += int'(pll_rst); end while (!ready && n < 200);
    checks++;
    if (rst_seen != 0 || rdy_seen != 0) begin
      errors++; $display("FAIL glitch_no_reset: got rst_cycles=%0d ready_cycles=%0d expected 0 0", rst_seen, rdy_seen);
    end
    checks++;
    if (n != SYNC + STB + 1) begin
      errors++; $display("FAIL glitch_ready_latency: got %0d expected %0d", n, SYNC + STB + 1);
    end
    checks++;
    if (retry_count !== 4'd0) begin
      errors++; $display("FAIL glitch_retry: got %0d expected 0", retry_count);
    end
  endtask

  task automatic test_timeout_fault();
    bit trace[$];
    int lens[$];
    bit lvls[$];
    bit seen_fault;
    seen_fault = 1'b0;
    @(negedge refclk); pll_locked = 1'b0; relock_req = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(posedge refclk); #1;
      if (fault) begin seen_fault = 1'b1; break; end
      trace.push_back(pll_rst);
      @(negedge refclk); relock_req = 1'b0;
    end
    relock_req = 1'b0;
    checks++;
    if (!seen_fault || {pll_rst, ready, retry_count} !== {1'b1, 1'b0, 4'(MAXR)}) begin
      errors++; $display("FAIL fault_entry: got fault=%b pll_rst=%b ready=%b retry=%0d expected 1 1 0 %0d",
                         fault, pll_rst, ready, retry_count, MAXR);
    end
    foreach (trace[i]) begin
      if (i == 0 || trace[i] != trace[i-1]) begin lens.push_back(1); lvls.push_back(trace[i]); end
      else lens[lens.size()-1]++;
    end
    checks++;
    if (lens.size() != 2 * (MAXR + 1)) begin
      errors++; $display("FAIL fault_pulse_count: got %0d runs expected %0d", lens.size(), 2 * (MAXR + 1));
    end
    for (int r = 0; r < 2 * (MAXR + 1) && r < lens.size(); r++) begin
      checks++;
      if (lvls[r] != (r % 2 == 0) || lens[r] != ((r % 2 == 0) ? HOLD : TMO)) begin
        errors++; $display("FAIL fault_run_%0d: got level=%b len=%0d expected level=%b len=%0d",
                           r, lvls[r], lens[r], r % 2 == 0, (r % 2 == 0) ? HOLD : TMO);
      end
    end
  endtask

  task automatic test_fault_recovery();
    int bad, fell_at;
    bad = 0; fell_at = 0;
    repeat (20) begin @(posedge refclk); #1; if (!fault || !pll_rst) bad++; end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL fault_hold: got %0d bad cycles expected 0", bad);
    end
    @(negedge refclk); relock_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge refclk); #1;
      if (k == 1) begin
        checks++;
        if ({fault, pll_rst, retry_count} !== {1'b0, 1'b1, 4'd0}) begin
          errors++; $display("FAIL recover_exit: got fault=%b pll_rst=%b retry=%0d expected 0 1 0",
                             fault, pll_rst, retry_count);
        end
      end
      if (!pll_rst) begin fell_at = k; break; end
      @(negedge refclk); relock_req = 1'b0;
    end
    relock_req = 1'b0;
    checks++;
    if (fell_at != HOLD + 1) begin
      errors++; $display("FAIL recover_rst_len: got %0d expected %0d", fell_at, HOLD + 1);
    end
    repeat (10) @(posedge refclk);
    @(negedge refclk); enable = 1'b0;
    @(posedge refclk); #1;
    checks++;
    if ({pll_rst, ready, fault} !== 3'b100) begin
      errors++; $display("FAIL disable_idle: got %b expected 100", {pll_rst, ready, fault});
    end
    bad = 0;
    repeat (20) begin @(posedge refclk); #1; if (!pll_rst) bad++; end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL idle_hold: got %0d low cycles expected 0", bad);
    end
    @(negedge refclk); enable = 1'b1;
  endtask

  task automatic test_random();
    int run_left, r;
    bit lvl;
    lvl = pll_locked; run_left = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge refclk);
      if (run_left == 0) begin
        lvl = !lvl;
        if (lvl) run_left = int'($urandom_range(20, 400));
        else begin
          r = int'($urandom_range(0, 9));
          run_left = (r < 5) ? int'($urandom_range(1, 6)) :
                     (r < 7) ? int'($urandom_range(7, 120)) : int'($urandom_range(300, 450));
        end
      end
      run_left--;
      pll_locked = lvl;
      enable     = ($urandom_range(0, 249) != 0);
      relock_req = ($urandom_range(0, 399) == 0);
      @(posedge refclk); #1;
      checks++;
      if (dut_vec !== model_outs()) begin
        errors++; $display("FAIL random_cycle_%0d: got %h expected %h", c, dut_vec, model_outs());
      end
    end
    @(negedge refclk); relock_req = 1'b0; enable = 1'b1;
  endtask

  task automatic test_async_reset();
    int n;
    @(negedge refclk); pll_locked = 1'b1; enable = 1'b1; relock_req = 1'b0;
    @(negedge refclk); pll_locked = 1'b0;
    repeat (5) @(negedge refclk);
    pll_locked = 1'b1;
    n = 0;
    do begin @(posedge refclk); #1; n++; end while (!ready && n < 300);
    checks++;
    if (ready !== 1'b1 || lol_count === 8'd0) begin
      errors++; $display("FAIL async_pre_run: got ready=%b lol=%0d expected 1 nonzero", ready, lol_count);
    end
    @(posedge refclk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== RESET_VEC) begin
      errors++; $display("FAIL async_reset_values: got %h expected %h", dut_vec, RESET_VEC);
    end
    #4 rst_n = 1'b1;
    @(posedge refclk); #1;
    checks++;
    if (dut_vec !== model_outs() || pll_rst !== 1'b1 || ready !== 1'b0) begin
      errors++; $display("FAIL async_after_release: got %h expected %h", dut_vec, model_outs());
    end
  endtask

  initial begin
    test_reset();
    test_clean_bringup();
    test_loss_of_lock();
    test_lock_glitch();
    test_timeout_fault();
    test_fault_recovery();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
